// File: rtl/explore_pkg.sv
// Shared types and constants for the explore sequencer and its operand shifter.
package explore_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned LatW         = 3;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/serial_operand_shreg.sv
// Two MSB-first serial-to-parallel operand registers sharing one bit counter.
module serial_operand_shreg
  import explore_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_ser_a,
  input  logic             i_ser_b,
  output logic [WIDTH-1:0] o_op_a,
  output logic [WIDTH-1:0] o_op_b,
  output logic             o_last
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [CntW-1:0]  r_cnt;

  assign o_last = (r_cnt == CntW'(WIDTH - 1));
  assign o_op_a = r_op_a;
  assign o_op_b = r_op_b;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_op_a <= '0;
      r_op_b <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      // Operands keep their old contents; only the bit count restarts.
      r_cnt <= '0;
    end else if (i_shift) begin
      r_op_a <= {r_op_a[WIDTH-2:0], i_ser_a};
      r_op_b <= {r_op_b[WIDTH-2:0], i_ser_b};
      r_cnt  <= o_last ? '0 : r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/explore_sequencer.sv
// Loads two serial operands, waits a configurable latency for the datapath,
// captures its result and exposes it byte by byte.
module explore_sequencer
  import explore_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            ser_a,
  input  logic            ser_b,
  input  logic [LatW-1:0] lat_cfg,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic            op_valid,
  input  logic [WIDTH:0]  res_in,
  input  logic [2:0]      byte_sel,
  output logic [7:0]      dout,
  output logic            busy,
  output logic            done
);

  state_e          r_state;
  state_e          w_state_d;
  logic [LatW-1:0] r_wait;
  logic [WIDTH:0]  r_result;
  logic            w_shift;
  logic            w_clr;
  logic            w_latch;
  logic            w_capture;
  logic            w_dec;
  logic            w_last;
  logic [63:0]     w_res_ext;

  serial_operand_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clr   (w_clr),
    .i_shift (w_shift),
    .i_ser_a (ser_a),
    .i_ser_b (ser_b),
    .o_op_a  (op_a),
    .o_op_b  (op_b),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_wait   <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_latch) begin
        r_wait <= lat_cfg;
      end else if (w_dec) begin
        r_wait <= r_wait - LatW'(1);
      end
      if (w_capture) begin
        r_result <= res_in;
      end
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_shift   = 1'b0;
    w_clr     = 1'b0;
    w_latch   = 1'b0;
    w_capture = 1'b0;
    w_dec     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    op_valid  = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        done = (r_state == StDone);
        if (start) begin
          w_state_d = StLoad;
          w_clr     = 1'b1;
          w_latch   = 1'b1;
        end
      end
      StLoad: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (w_last) w_state_d = StIssue;
      end
      StIssue: begin
        busy     = 1'b1;
        op_valid = 1'b1;
        if (r_wait == '0) begin
          w_state_d = StDone;
          w_capture = 1'b1;
        end else begin
          w_state_d = StWait;
        end
      end
      StWait: begin
        busy     = 1'b1;
        op_valid = 1'b1;
        w_dec    = 1'b1;
        if (r_wait == LatW'(1)) begin
          w_state_d = StDone;
          w_capture = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
    // Abort freezes operands, counters and result; only the state moves.
    if (abort) begin
      w_state_d = StIdle;
      w_shift   = 1'b0;
      w_clr     = 1'b0;
      w_latch   = 1'b0;
      w_capture = 1'b0;
      w_dec     = 1'b0;
    end
  end

  assign w_res_ext = 64'(r_result);
  assign dout      = w_res_ext[{byte_sel, 3'b000} +: 8];

endmodule
